// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 message padder: FSM state encoding,
// block geometry constants and the last-word padding helper.
// -----------------------------------------------------------------------------
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,   // waiting for the first word of a message
    CLR,    // pulse core_rst to reinitialise the hash chaining state
    FILL,   // accept message words into the block buffer
    PAD,    // place the 0x80 marker (if still pending) and zero-fill
    LENW,   // write the 64-bit bit length into words 14/15
    ISSUE,  // pulse core_start
    WAIT    // hold the block until core_done
  } state_t;

  localparam int         WORDS_PER_BLOCK = 16;
  localparam logic [7:0] PAD_BYTE        = 8'h80;
  localparam int         LEN_WORD_HI     = 14;

  // Keep the first nbytes bytes of a big-endian word, follow them with the
  // 0x80 marker and clear the rest. nbytes == 0 means the word is full, so
  // it is returned untouched and the marker goes into the next word.
  function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                input logic [1:0]  nbytes);
    case (nbytes)
      2'd1:    return {data[31:24], PAD_BYTE, 16'h0000};
      2'd2:    return {data[31:16], PAD_BYTE, 8'h00};
      2'd3:    return {data[31:8],  PAD_BYTE};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// -----------------------------------------------------------------------------
// sha256_padder
// Accepts a stream of 32-bit big-endian message words, builds 512-bit
// SHA-256 blocks with standard padding (0x80 marker, zero fill, 64-bit bit
// length) and hands them one at a time to a downstream compression core.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       synchronous active-high reset
//   in_valid    upstream word valid
//   in_ready    padder accepts a word this cycle (FILL only)
//   in_data     message word, in_data[31:24] is the first byte
//   in_last     current word is the final word of the message
//   in_bytes    valid bytes in the final word (0 means 4)
//   core_rst    one-cycle pulse, reinitialise the core's chaining state
//   core_start  one-cycle pulse, compress core_block
//   core_block  padded block, word i at bits [32*i+31 : 32*i]
//   core_done   one-cycle pulse from the core, compression finished
//   msg_done    one-cycle pulse, final block of the message completed
// -----------------------------------------------------------------------------
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int MAX_BLOCKS = 2**20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         core_rst,
  output logic         core_start,
  output logic [511:0] core_block,
  input  logic         core_done,
  output logic         msg_done
);

  // The bit length never exceeds MAX_BLOCKS * 512, so only enough bits to
  // hold that are stored; the upper bits of the 64-bit length are zero.
  localparam int LEN_W = $clog2(MAX_BLOCKS) + 10;

  state_t             r_state,      w_state_nxt;
  logic [4:0]         r_widx,       w_widx_nxt;
  logic [LEN_W-1:0]   r_len,        w_len_nxt;
  logic [511:0]       r_block,      w_block_nxt;
  logic               r_pad_pend,   w_pad_pend_nxt;   // 0x80 still owed
  logic               r_final,      w_final_nxt;      // block carries length
  logic               r_resume_pad, w_resume_pad_nxt; // after WAIT go to PAD

  logic [63:0]        w_len64;
  logic [5:0]         w_add_bits;

  assign w_len64    = 64'(r_len);
  assign w_add_bits = (in_last && (in_bytes != 2'd0)) ? 6'({in_bytes, 3'b000})
                                                      : 6'd32;
  assign core_block = r_block;

  // Word-placement mux: drop a 32-bit word into slot idx of the block.
  function automatic logic [511:0] put_word(input logic [511:0] blk,
                                            input logic [3:0]   idx,
                                            input logic [31:0]  word);
    logic [511:0] res;
    res = blk;
    res[{idx, 5'b00000} +: 32] = word;
    return res;
  endfunction

  // NOTE: the block buffer is reset like every other register here, because
  // core_block is visible on a port and must read as zero after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state      <= IDLE;
      r_widx       <= '0;
      r_len        <= '0;
      r_block      <= '0;
      r_pad_pend   <= 1'b0;
      r_final      <= 1'b0;
      r_resume_pad <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_widx       <= w_widx_nxt;
      r_len        <= w_len_nxt;
      r_block      <= w_block_nxt;
      r_pad_pend   <= w_pad_pend_nxt;
      r_final      <= w_final_nxt;
      r_resume_pad <= w_resume_pad_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_nxt      = r_state;
    w_widx_nxt       = r_widx;
    w_len_nxt        = r_len;
    w_block_nxt      = r_block;
    w_pad_pend_nxt   = r_pad_pend;
    w_final_nxt      = r_final;
    w_resume_pad_nxt = r_resume_pad;
    in_ready         = 1'b0;
    core_rst         = 1'b0;
    core_start       = 1'b0;
    msg_done         = 1'b0;

    case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = CLR;
      end

      CLR: begin
        core_rst       = 1'b1;
        w_widx_nxt     = '0;
        w_len_nxt      = '0;
        w_pad_pend_nxt = 1'b0;
        w_final_nxt    = 1'b0;
        w_state_nxt    = FILL;
      end

      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_len_nxt  = r_len + LEN_W'(w_add_bits);
          w_widx_nxt = r_widx + 5'd1;
          if (in_last) begin
            w_block_nxt    = put_word(r_block, r_widx[3:0],
                                      pad_last_word(in_data, in_bytes));
            w_pad_pend_nxt = (in_bytes == 2'd0);
            w_state_nxt    = PAD;
          end else begin
            w_block_nxt = put_word(r_block, r_widx[3:0], in_data);
            if (r_widx == 5'(WORDS_PER_BLOCK - 1)) begin
              w_resume_pad_nxt = 1'b0;
              w_state_nxt      = ISSUE;
            end
          end
        end
      end

      // One word per cycle. A full block is flushed first; the marker is
      // placed before any zero fill; landing exactly on word 14 means the
      // length fits in this block.
      PAD: begin
        if (r_widx == 5'(WORDS_PER_BLOCK)) begin
          w_resume_pad_nxt = 1'b1;
          w_state_nxt      = ISSUE;
        end else if (r_pad_pend) begin
          w_block_nxt    = put_word(r_block, r_widx[3:0], {PAD_BYTE, 24'h0});
          w_pad_pend_nxt = 1'b0;
          w_widx_nxt     = r_widx + 5'd1;
        end else if (r_widx == 5'(LEN_WORD_HI)) begin
          w_state_nxt = LENW;
        end else begin
          w_block_nxt = put_word(r_block, r_widx[3:0], 32'h0);
          w_widx_nxt  = r_widx + 5'd1;
        end
      end

      LENW: begin
        w_block_nxt = put_word(put_word(r_block, 4'(LEN_WORD_HI), w_len64[63:32]),
                               4'(LEN_WORD_HI + 1), w_len64[31:0]);
        w_final_nxt = 1'b1;
        w_state_nxt = ISSUE;
      end

      ISSUE: begin
        core_start  = 1'b1;
        w_state_nxt = WAIT;
      end

      WAIT: begin
        if (core_done) begin
          w_widx_nxt = '0;
          if (r_final) begin
            msg_done    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = r_resume_pad ? PAD : FILL;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha256_padder.sv
// -----------------------------------------------------------------------------
// tb_sha256_padder
// Directed bench for sha256_padder. The bench plays the compression core
// (captures core_block on core_start, answers core_done a few cycles later)
// and compares every captured block against SHA-256 padding rebuilt from the
// message bytes, plus hand-computed words for the named vectors.
// -----------------------------------------------------------------------------
module tb_sha256_padder;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic         core_rst;
  logic         core_start;
  logic [511:0] core_block;
  logic         core_done;
  logic         msg_done;

  sha256_padder dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_bytes   (in_bytes),
    .core_rst   (core_rst),
    .core_start (core_start),
    .core_block (core_block),
    .core_done  (core_done),
    .msg_done   (msg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0]  msg [0:31];
  int           msg_n;
  logic [1:0]   msg_lb;
  logic [511:0] cap  [0:7];
  int           cap_n;
  logic [511:0] gold [0:7];
  int           gold_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input logic [1:0] lb, input logic [31:0] seed);
    msg_n  = n;
    msg_lb = lb;
    for (int i = 0; i < n; i++) msg[i] = seed + 32'(i) * 32'h0101_0101;
  endtask

  // Reference padding built byte by byte from the message.
  task automatic build_gold();
    logic [7:0]  q [$];
    logic [63:0] bitlen;
    logic [31:0] w;
    int          nb;
    for (int i = 0; i < msg_n; i++) begin
      w  = msg[i];
      nb = (i == msg_n - 1 && msg_lb != 2'd0) ? int'(msg_lb) : 4;
      for (int k = 0; k < nb; k++) q.push_back(w[31-8*k -: 8]);
    end
    bitlen = 64'(q.size()) * 64'd8;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int k = 0; k < 8; k++) q.push_back(bitlen[63-8*k -: 8]);
    gold_n = q.size() / 64;
    for (int b = 0; b < gold_n; b++)
      for (int i = 0; i < 16; i++)
        gold[b][32*i +: 32] = {q[64*b+4*i], q[64*b+4*i+1], q[64*b+4*i+2], q[64*b+4*i+3]};
  endtask

  task automatic run_msg(input string name, input bit abort_wait, input bit spurious);
    int           idx;
    int           timer;
    bit           done;
    bit           saw_rst;
    bit           wait_ok;
    bit           hold_ok;
    bit           real_done;
    bit           fake_done;
    logic [511:0] held;
    build_gold();
    cap_n   = 0;
    idx     = 0;
    timer   = 0;
    done    = 1'b0;
    saw_rst = 1'b0;
    wait_ok = 1'b1;
    hold_ok = 1'b1;
    held    = '0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(negedge clk);
      core_done = 1'b0;
      real_done = 1'b0;
      fake_done = 1'b0;
      if (core_rst === 1'b1) saw_rst = 1'b1;
      if (timer > 0) begin
        if (in_ready !== 1'b0) wait_ok = 1'b0;
        if (core_block !== held) hold_ok = 1'b0;
        if (abort_wait) begin
          reset    = 1'b1;
          in_valid = 1'b0;
          @(negedge clk);
          chk({name, "_rst_in_ready"},   64'(in_ready),   64'd0);
          chk({name, "_rst_core_rst"},   64'(core_rst),   64'd0);
          chk({name, "_rst_core_start"}, 64'(core_start), 64'd0);
          chk({name, "_rst_msg_done"},   64'(msg_done),   64'd0);
          chk({name, "_rst_block_zero"}, 64'(core_block == '0), 64'd1);
          reset = 1'b0;
          return;
        end
        timer--;
        if (timer == 0) begin
          core_done = 1'b1;
          real_done = 1'b1;
        end
      end
      if (core_start === 1'b1) begin
        if (cap_n == 0) chk({name, "_rst_before_start"}, 64'(saw_rst), 64'd1);
        if (cap_n < 8) cap[cap_n] = core_block;
        held  = core_block;
        cap_n++;
        timer = 3;
      end
      if (spurious && in_ready === 1'b1 && idx == 1) begin
        core_done = 1'b1;
        fake_done = 1'b1;
        spurious  = 1'b0;
      end
      if (idx < msg_n) begin
        in_valid = 1'b1;
        in_data  = msg[idx];
        in_last  = (idx == msg_n - 1);
        in_bytes = in_last ? msg_lb : 2'(idx);
        if (in_ready === 1'b1) idx++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #1;
      if (fake_done) chk({name, "_stray_done_ignored"}, 64'(msg_done), 64'd0);
      if (real_done) begin
        chk($sformatf("%s_msg_done_blk%0d", name, cap_n), 64'(msg_done),
            64'(cap_n == gold_n));
        if (msg_done === 1'b1) done = 1'b1;
      end
    end
    chk({name, "_finished"},       64'(done),    64'd1);
    chk({name, "_ready_low_wait"}, 64'(wait_ok), 64'd1);
    chk({name, "_block_held"},     64'(hold_ok), 64'd1);
    chk({name, "_words_taken"},    64'(idx),     64'(msg_n));
    chk({name, "_block_count"},    64'(cap_n),   64'(gold_n));
    for (int b = 0; b < gold_n && b < cap_n; b++)
      for (int i = 0; i < 16; i++)
        chk($sformatf("%s_b%0d_w%0d", name, b, i), 64'(cap[b][32*i +: 32]),
            64'(gold[b][32*i +: 32]));
    @(negedge clk);
    core_done = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bytes  = '0;
    core_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready",   64'(in_ready),   64'd0);
    chk("reset_core_rst",   64'(core_rst),   64'd0);
    chk("reset_core_start", 64'(core_start), 64'd0);
    chk("reset_msg_done",   64'(msg_done),   64'd0);
    chk("reset_block_zero", 64'(core_block == '0), 64'd1);
    reset = 1'b0;

    // "abc": one block, marker right after the third byte, length 24.
    msg_n = 1; msg_lb = 2'd3; msg[0] = 32'h6162_6300;
    run_msg("abc", 1'b0, 1'b0);
    chk("abc_blocks", 64'(cap_n), 64'd1);
    chk("abc_w0",     64'(cap[0][31:0]),    64'h6162_6380);
    chk("abc_w15",    64'(cap[0][511:480]), 64'h18);

    // 13 full words: marker in word 13, length still fits.
    load(13, 2'd0, 32'h1000_0000);
    run_msg("w13", 1'b0, 1'b0);
    chk("w13_blocks", 64'(cap_n), 64'd1);
    chk("w13_w13",    64'(cap[0][13*32 +: 32]), 64'h8000_0000);
    chk("w13_w15",    64'(cap[0][511:480]),     64'h1A0);

    // 14 full words: marker in word 14 forces a second block.
    load(14, 2'd0, 32'h0102_0304);
    run_msg("w14", 1'b0, 1'b0);
    chk("w14_blocks",  64'(cap_n), 64'd2);
    chk("w14_b0_w14",  64'(cap[0][14*32 +: 32]), 64'h8000_0000);
    chk("w14_b1_w15",  64'(cap[1][511:480]),     64'h1C0);

    // 16 full words: data block, then marker block.
    load(16, 2'd0, 32'hA0B0_C0D0);
    run_msg("w16", 1'b0, 1'b0);
    chk("w16_blocks", 64'(cap_n), 64'd2);
    chk("w16_b1_w0",  64'(cap[1][31:0]),    64'h8000_0000);
    chk("w16_b1_w15", 64'(cap[1][511:480]), 64'h200);

    // 20 words, in_valid held through WAIT, stray core_done during FILL.
    load(20, 2'd2, 32'h5566_7788);
    run_msg("w20", 1'b0, 1'b1);
    chk("w20_b1_w15", 64'(cap[1][511:480]), 64'd624);

    // Reset while the first block is in WAIT, then a fresh message.
    load(3, 2'd0, 32'hDEAD_BEEF);
    run_msg("abort", 1'b1, 1'b0);
    load(5, 2'd1, 32'h1357_9BDF);
    run_msg("after_abort", 1'b0, 1'b0);
    chk("after_abort_w15", 64'(cap[0][511:480]), 64'd136);

    // Back-to-back message: length must restart from zero.
    load(2, 2'd0, 32'h0F0F_0F0F);
    run_msg("b2b", 1'b0, 1'b0);
    chk("b2b_w15", 64'(cap[0][511:480]), 64'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`: input, 1 bit, synchronous active-high reset.
REQ-003 The block SHALL have the port `in_valid`: input, 1 bit, the upstream message word is valid.
REQ-004 The block SHALL have the port `in_ready`: output, 1 bit, the padder accepts a word this cycle.
REQ-005 The block SHALL have the port `in_data`: input, 32 bits, message word; byte order big-endian, `in_data[31:24]` is the first byte.
REQ-006 The block SHALL have the port `in_last`: input, 1 bit, the current word is the final word of the message.
REQ-007 The block SHALL have the port `in_bytes`: input, 2 bits, valid bytes in the last word (0 means 4); ignored when `in_last`=0.
REQ-008 The block SHALL have the port `core_rst`: output, 1 bit, one-cycle pulse that reinitialises the downstream hash core's chaining state.
REQ-009 The block SHALL have the port `core_start`: output, 1 bit, one-cycle pulse that launches compression of `core_block`.
REQ-010 The block SHALL have the port `core_block`: output, 512 bits, padded block; message word i SHALL sit at bits [32*i+31 : 32*i].
REQ-011 The block SHALL have the port `core_done`: input, 1 bit, one-cycle pulse from the core when the compression has finished.
REQ-012 The block SHALL have the port `msg_done`: output, 1 bit, one-cycle pulse when the final block of a message has completed.
REQ-013 The parameter `MAX_BLOCKS` SHALL default to 2^20; a message longer than this many blocks is out of scope.

Function
REQ-014 The FSM SHALL have the states IDLE, CLR, FILL, PAD, LENW, ISSUE, WAIT.
REQ-015 IDLE SHALL go to CLR on `in_valid`; CLR SHALL assert `core_rst` for 1 cycle, then go to FILL.
REQ-016 In FILL, `in_ready`=1; each accepted word SHALL be written to word index `widx`, `widx` SHALL increment, and the 64-bit bit length SHALL add 32 (or 8*`in_bytes` on the last word).
REQ-017 `widx` reaching 16 in FILL without `in_last` SHALL go to ISSUE; after that block's `core_done`, `widx`=0 and the FSM SHALL return to FILL.
REQ-018 On the last word, the byte following the final valid byte SHALL be 0x80 and the remaining bytes 0x00; if `in_bytes`=0 (full word), the 0x80 SHALL occupy the next word.
REQ-019 After padding, if the next free word index is 14 or less, the block SHALL zero-fill to word 13 and then write word 14 = length[63:32] and word 15 = length[31:0] (LENW).
REQ-020 Otherwise the block SHALL zero-fill to word 15, issue the block, then build an extra block of zeros plus the length words.
REQ-021 ISSUE SHALL pulse `core_start` for 1 cycle and go to WAIT; `core_block` SHALL be held constant from `core_start` until `core_done`.
REQ-022 The next `core_start` SHALL NOT occur before the cycle after `core_done`; `core_rst` SHALL precede the message's first `core_start` by at least 1 cycle.
REQ-023 `core_done` for the final block SHALL pulse `msg_done` in the same cycle and return the FSM to IDLE.
REQ-024 `in_ready`=0 outside FILL; `core_done` arriving outside WAIT SHALL be ignored.
REQ-025 A zero-length message is not expressible (every message contains at least one word).

Reset
REQ-026 `reset` SHALL force IDLE, `widx`=0, length=0, and outputs `in_ready`=0, `core_rst`=0, `core_start`=0, `msg_done`=0, `core_block`=0.
REQ-027 `reset` mid-message SHALL abandon the message with no `msg_done`; the next message SHALL begin with `core_rst`.

Structure
REQ-028 A shared package `sha256_pkg` SHALL hold the FSM state enum, WORDS_PER_BLOCK=16, PAD_BYTE=8'h80 and LEN_WORD_HI=14.
REQ-029 No sub-module is required; the word-placement mux SHALL be an internal function.

Verification
REQ-030 The bench SHALL cover "abc" (one word 0x61626300, `in_bytes`=3): 1 block, word0=0x61626380, words 1-14=0, word15=0x18; `msg_done` after 1 `core_done`.
REQ-031 The bench SHALL cover 14 full words: word14=0x80000000 forces a second block; block 2 word15=0x1C0, `core_start` count=2.
REQ-032 The bench SHALL cover 16 full words: block 1 = the data, block 2 word0=0x80000000 and word15=0x200.
REQ-033 The bench SHALL cover `in_valid` held high during WAIT: `in_ready`=0 and no word is lost; the block contents match the golden SHA-256 padding.
REQ-034 The bench SHALL cover `reset` asserted in WAIT: outputs at reset values next cycle; the following message produces `core_rst` then correct blocks.
REQ-035 The bench SHALL cover back-to-back messages: `core_rst` between them and a correct length count per message (no carry-over).
